// File: rtl/hc595_chain_driver_if.sv
// hc595_chain_driver_if: bundles the request side and the 74HC595 pin side of
// hc595_chain_driver.
//   data   frame to shift (DATA_W bits), sampled when a start is accepted
//   start  transfer request
//   busy   frame in flight
//   done   one-cycle pulse at the end of the latch pulse
//   sh_cp  shift clock to the chain
//   st_cp  storage (latch) clock to the chain
//   ds     serial data to the first 595
// master: the requester (drives data/start, observes everything else).
// slave:  the driver itself.
interface hc595_chain_driver_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] data;
    logic              start;
    logic              busy;
    logic              done;
    logic              sh_cp;
    logic              st_cp;
    logic              ds;

    modport master (
        output data, start,
        input  busy, done, sh_cp, st_cp, ds
    );

    modport slave (
        input  data, start,
        output busy, done, sh_cp, st_cp, ds
    );
endinterface

// File: rtl/hc595_chain_driver.sv
// hc595_chain_driver: start/busy/done serial engine for a cascade of 74HC595s.
// Each accepted start shifts one DATA_W-bit frame on sh_cp/ds, then issues a
// single st_cp latch pulse and a one-cycle done pulse. Every phase (sh_cp low,
// sh_cp high, st_cp high) lasts CLK_DIV clk cycles.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      hc595_chain_driver_if.slave (data, start, busy, done, sh_cp, st_cp, ds)
// Parameters: DATA_W, CLK_DIV, LSB_FIRST, REFRESH_CYC.
// Optional feature: define HC595_AUTO_REFRESH_EN to re-send the current data
// automatically after REFRESH_CYC idle cycles.
module hc595_chain_driver #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned LSB_FIRST   = 0,
    parameter int unsigned REFRESH_CYC = 50000
) (
    input logic                   clk,
    input logic                   reset_n,
    hc595_chain_driver_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

    typedef enum logic [1:0] {StIdle, StShiftLo, StShiftHi, StLatch} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic              ds_q, ds_d;
    logic              sh_cp_q, sh_cp_d;
    logic              st_cp_q, st_cp_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick;
    logic              start_go;

    function automatic logic first_bit(input logic [DATA_W-1:0] d);
        return (LSB_FIRST != 0) ? d[0] : d[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] d);
        return (LSB_FIRST != 0) ? (d >> 1) : (d << 1);
    endfunction

`ifdef HC595_AUTO_REFRESH_EN
    localparam int unsigned IDLE_W = $clog2(REFRESH_CYC + 1);

    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              refresh_go;

    // Counts only while idle; any frame (external or internal) restarts it.
    assign refresh_go = (idle_cnt_q == IDLE_W'(REFRESH_CYC - 1));
    assign start_go   = (state_q == StIdle) && (bus.start || refresh_go);

    always_comb begin
        idle_cnt_d = '0;
        if ((state_q == StIdle) && !start_go) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign start_go = (state_q == StIdle) && bus.start;
`endif

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        sreg_d    = sreg_q;
        ds_d      = ds_q;
        sh_cp_d   = sh_cp_q;
        st_cp_d   = st_cp_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                div_d = '0;
                if (start_go) begin
                    sreg_d    = bus.data;
                    bit_cnt_d = CNT_W'(DATA_W);
                    ds_d      = first_bit(bus.data);
                    sh_cp_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = StShiftLo;
                end
            end
            StShiftLo: begin
                if (tick) begin
                    div_d   = '0;
                    sh_cp_d = 1'b1;
                    state_d = StShiftHi;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            StShiftHi: begin
                if (tick) begin
                    div_d   = '0;
                    sh_cp_d = 1'b0;
                    // bit_cnt_q counts the bit currently on ds as well.
                    if (bit_cnt_q != CNT_W'(1)) begin
                        sreg_d    = advance(sreg_q);
                        ds_d      = first_bit(advance(sreg_q));
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                        state_d   = StShiftLo;
                    end else begin
                        bit_cnt_d = '0;
                        ds_d      = 1'b0;
                        st_cp_d   = 1'b1;
                        state_d   = StLatch;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            StLatch: begin
                if (tick) begin
                    div_d   = '0;
                    st_cp_d = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_cnt_q <= '0;
            sreg_q    <= '0;
            ds_q      <= 1'b0;
            sh_cp_q   <= 1'b0;
            st_cp_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            sreg_q    <= sreg_d;
            ds_q      <= ds_d;
            sh_cp_q   <= sh_cp_d;
            st_cp_q   <= st_cp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sh_cp = sh_cp_q;
    assign bus.st_cp = st_cp_q;
    assign bus.ds    = ds_q;

endmodule

// File: tb/tb_hc595_chain_driver.sv
// tb_hc595_chain_driver: directed bench for hc595_chain_driver.
// dut_a: DATA_W=16, CLK_DIV=2, MSB first. dut_b: DATA_W=8, CLK_DIV=1, LSB first.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_hc595_chain_driver;
    logic clk = 1'b0;
    logic reset_n;

    int n_cmp = 0;
    int n_bad = 0;

    hc595_chain_driver_if #(.DATA_W(16)) if_a ();
    hc595_chain_driver_if #(.DATA_W(8))  if_b ();

    hc595_chain_driver #(
        .DATA_W    (16),
        .CLK_DIV   (2),
        .LSB_FIRST (0)
    ) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_a)
    );

    hc595_chain_driver #(
        .DATA_W    (8),
        .CLK_DIV   (1),
        .LSB_FIRST (1)
    ) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] pins_a();
        return {if_a.busy, if_a.done, if_a.sh_cp, if_a.st_cp, if_a.ds};
    endfunction

    function automatic logic [4:0] pins_b();
        return {if_b.busy, if_b.done, if_b.sh_cp, if_b.st_cp, if_b.ds};
    endfunction

    // Observe max_cyc cycles after the accepting edge. ds is collected at each
    // sh_cp rise (first bit ends up most significant). If pulse_at >= 0, start
    // is pulsed on dut_a and its data changed to 16'hFFFF at that cycle.
    task automatic capture(input bit use_b, input int max_cyc, input int pulse_at,
                           output logic [15:0] bits, output int rises, output int first_rise,
                           output int st_first, output int st_last, output int done_at,
                           output int done_cnt, output int busy_hi);
        logic prev_sh = 1'b0;
        logic sh, st, dn, by, d;
        bits = '0; rises = 0; first_rise = -1; st_first = -1; st_last = -1;
        done_at = -1; done_cnt = 0; busy_hi = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            step();
            sh = use_b ? if_b.sh_cp : if_a.sh_cp;
            st = use_b ? if_b.st_cp : if_a.st_cp;
            dn = use_b ? if_b.done  : if_a.done;
            by = use_b ? if_b.busy  : if_a.busy;
            d  = use_b ? if_b.ds    : if_a.ds;
            if (sh && !prev_sh) begin
                bits = {bits[14:0], d};
                rises++;
                if (first_rise < 0) first_rise = c;
            end
            if (st) begin
                if (st_first < 0) st_first = c;
                st_last = c;
            end
            if (dn) begin
                done_at = c;
                done_cnt++;
            end
            if (by) busy_hi++;
            prev_sh = sh;
            if (c == pulse_at) begin
                if_a.start = 1'b1;
                if_a.data  = 16'hFFFF;
            end
            if (pulse_at >= 0 && c == pulse_at + 1) if_a.start = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] bits;
        int rises, first_rise, st_first, st_last, done_at, done_cnt, busy_hi;

        // Reset held with start high: everything stays quiet.
        reset_n    = 1'b0;
        if_a.start = 1'b1;
        if_a.data  = 16'hA5C3;
        if_b.start = 1'b0;
        if_b.data  = 8'h00;
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_pins_a", 32'(pins_a()), 32'h0);
        end
        check("reset_pins_b", 32'(pins_b()), 32'h0);

        // Release: the next edge accepts the pending start.
        reset_n = 1'b1;
        step();
        check("accept_busy", 32'(if_a.busy), 32'h1);
        check("accept_ds_first", 32'(if_a.ds), 32'h1);
        check("accept_sh_low", 32'(if_a.sh_cp), 32'h0);
        if_a.start = 1'b0;
        capture(1'b0, 80, -1, bits, rises, first_rise, st_first, st_last, done_at,
                done_cnt, busy_hi);
        check("a5c3_bits", 32'(bits), 32'hA5C3);
        check("a5c3_rises", 32'(rises), 32'd16);
        check("a5c3_first_rise", 32'(first_rise), 32'd2);
        check("a5c3_st_first", 32'(st_first), 32'd64);
        check("a5c3_st_last", 32'(st_last), 32'd65);
        check("a5c3_done_at", 32'(done_at), 32'd66);
        check("a5c3_done_cnt", 32'(done_cnt), 32'd1);
        check("a5c3_busy_cycles", 32'(busy_hi), 32'd65);
        check("idle_pins_a", 32'(pins_a()), 32'h0);
        check("b_untouched", 32'(pins_b()), 32'h0);

        // Start and data change while busy are ignored.
        if_a.start = 1'b1;
        step();
        if_a.start = 1'b0;
        capture(1'b0, 80, 10, bits, rises, first_rise, st_first, st_last, done_at,
                done_cnt, busy_hi);
        check("proto_bits", 32'(bits), 32'hA5C3);
        check("proto_done_cnt", 32'(done_cnt), 32'd1);
        check("proto_done_at", 32'(done_at), 32'd66);
        check("proto_busy_cycles", 32'(busy_hi), 32'd65);

        // Start held high: back-to-back frames with one idle cycle between.
        if_a.data  = 16'h00FF;
        if_a.start = 1'b1;
        step();
        capture(1'b0, 67, -1, bits, rises, first_rise, st_first, st_last, done_at,
                done_cnt, busy_hi);
        check("b2b_bits", 32'(bits), 32'h00FF);
        check("b2b_done_at", 32'(done_at), 32'd66);
        check("b2b_busy_cycles", 32'(busy_hi), 32'd66);
        check("b2b_restart_busy", 32'(if_a.busy), 32'h1);
        if_a.start = 1'b0;
        capture(1'b0, 80, -1, bits, rises, first_rise, st_first, st_last, done_at,
                done_cnt, busy_hi);
        check("b2b2_bits", 32'(bits), 32'h00FF);
        check("b2b2_done_at", 32'(done_at), 32'd66);
        check("b2b2_done_cnt", 32'(done_cnt), 32'd1);

        // Reset mid-frame while sh_cp is high.
        if_a.data  = 16'hA5C3;
        if_a.start = 1'b1;
        step();
        if_a.start = 1'b0;
        for (int i = 0; i < 22; i++) step();
        check("midrst_pre_sh", 32'(if_a.sh_cp), 32'h1);
        reset_n = 1'b0;
        #1;
        check("midrst_async_pins", 32'(pins_a()), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_hold_pins", 32'(pins_a()), 32'h0);
        end
        reset_n    = 1'b1;
        if_a.data  = 16'h3C5A;
        if_a.start = 1'b1;
        step();
        if_a.start = 1'b0;
        capture(1'b0, 80, -1, bits, rises, first_rise, st_first, st_last, done_at,
                done_cnt, busy_hi);
        check("fresh_bits", 32'(bits), 32'h3C5A);
        check("fresh_rises", 32'(rises), 32'd16);
        check("fresh_done_at", 32'(done_at), 32'd66);
        check("fresh_done_cnt", 32'(done_cnt), 32'd1);

        // LSB-first 8-bit chain at full rate.
        if_b.data  = 8'h01;
        if_b.start = 1'b1;
        step();
        if_b.start = 1'b0;
        check("b_accept_busy", 32'(if_b.busy), 32'h1);
        check("b_ds_first", 32'(if_b.ds), 32'h1);
        capture(1'b1, 25, -1, bits, rises, first_rise, st_first, st_last, done_at,
                done_cnt, busy_hi);
        check("b01_bits", 32'(bits), 32'h0080);
        check("b01_rises", 32'(rises), 32'd8);
        check("b01_first_rise", 32'(first_rise), 32'd1);
        check("b01_st_first", 32'(st_first), 32'd16);
        check("b01_st_last", 32'(st_last), 32'd16);
        check("b01_done_at", 32'(done_at), 32'd17);
        check("b01_busy_cycles", 32'(busy_hi), 32'd16);

        // 8'hB4 LSB first sends 0,0,1,0,1,1,0,1.
        if_b.data  = 8'hB4;
        if_b.start = 1'b1;
        step();
        if_b.start = 1'b0;
        capture(1'b1, 25, -1, bits, rises, first_rise, st_first, st_last, done_at,
                done_cnt, busy_hi);
        check("bb4_bits", 32'(bits), 32'h002D);
        check("bb4_done_cnt", 32'(done_cnt), 32'd1);
        check("idle_pins_b", 32'(pins_b()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
